alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth in entries; power of two, 2..16.
REQ-002 Parameter SETTLE_CYC, default 1, cycles ALU operands are held before result capture; range 1..15.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command present; cmd_ready  out  1  queue can accept.
REQ-006 cmd_sel  in  4  ALU opcode; cmd_a  in  4  operand A; cmd_b  in  4  operand B.
REQ-007 alu_sel  out  4, alu_a  out  4, alu_b  out  4  registered drives to the combinational ALU.
REQ-008 alu_out  in  8  ALU result; alu_carry  in  1  ALU carry/borrow flag.
REQ-009 rsp_valid  out  1  result held; rsp_ready  in  1  consumer accepts.
REQ-010 rsp_data  out  8, rsp_carry  out  1, rsp_err  out  1  captured result, carry, error flag.

Function
REQ-011 Command accepted on an edge where cmd_valid && cmd_ready; entry {sel,a,b} written to FIFO tail.
REQ-012 cmd_ready = !full; no push when full, even if a pop occurs on the same edge.
REQ-013 Pop only from a FIFO non-empty before the edge; no fall-through, so push and pop of the same entry on one edge never occurs.
REQ-014 FSM states: IDLE, DRIVE, RESP; one-hot or binary, implementer's choice.
REQ-015 IDLE: FIFO non-empty -> pop, load alu_sel/alu_a/alu_b, load settle counter with SETTLE_CYC-1, go DRIVE; else stay.
REQ-016 DRIVE: counter != 0 -> decrement; counter == 0 -> capture alu_out/alu_carry into rsp_data/rsp_carry, set rsp_valid, go RESP.
REQ-017 alu_* outputs stay stable from pop through capture; they hold last value in RESP and IDLE.
REQ-018 RESP: rsp_data/rsp_carry/rsp_err stable while rsp_valid && !rsp_ready.
REQ-019 RESP with rsp_ready: clear rsp_valid; FIFO non-empty -> pop on same edge, go DRIVE; else go IDLE.
REQ-020 Latency: command accepted into empty FIFO in cycle N with idle FSM -> rsp_valid high in cycle N+SETTLE_CYC+2.
REQ-021 Throughput: one result per SETTLE_CYC+1 cycles with rsp_ready held high.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter of width clog2(FIFO_DEPTH)+1 distinguishes full from empty.

Reset
REQ-023 rst_n low: FIFO emptied, FSM to IDLE, counter 0, immediately and independent of clk.
REQ-024 Reset values: cmd_ready 0 while rst_n low and 1 after release with empty FIFO; alu_sel/alu_a/alu_b 0; rsp_valid 0; rsp_data 0; rsp_carry 0; rsp_err 0.
REQ-025 Reset mid-operation discards the in-flight command and all queued commands; no response is produced for them.

Configuration
REQ-026 Macro ALU_SEQ_ERR_CHECK_EN defined: rsp_err = 1 at capture when sel is 4'b1001 or 4'b1010 with b == 0, or sel > 4'b1100; rsp_data and rsp_carry forced 0 for that response.
REQ-027 ALU_SEQ_ERR_CHECK_EN undefined: no check logic; rsp_err tied 0; ALU result passed unmodified.

Structure
REQ-028 Shared package alu_pkg holds opcode localparams (ALU_ADD 4'b0000 ... ALU_EQ 4'b1100), the command struct {sel,a,b} and the FSM state typedef.
REQ-029 One sub-module, alu_cmd_fifo: synchronous FIFO parameterised by depth and width, with push/pop/full/empty outputs.

Verification
REQ-030 Single op: push {0000,3,4}, SETTLE_CYC=1, rsp_ready=1 -> rsp_valid in cycle N+3, rsp_data 8'h07, rsp_carry 0.
REQ-031 Backpressure: push 6 commands with rsp_ready=0, FIFO_DEPTH=4 -> cmd_ready low after 4 queued plus 1 in flight, first response {sel 0010: 4'hC & 4'hA} = 8'h08 held stable.
REQ-032 Error check enabled: push {1001,7,0} -> rsp_err 1, rsp_data 0; push {1001,7,2} -> rsp_err 0, rsp_data 8'h03.
REQ-033 Reset mid-op: 3 queued, assert rst_n low during DRIVE -> rsp_valid 0 and alu_* 0 at once; after release no responses, cmd_ready 1.
REQ-034 Streaming: 8 back-to-back multiplies {1000,15,15} with rsp_ready=1, SETTLE_CYC=2 -> each rsp_data 8'hE1, responses spaced 3 cycles.
REQ-035 Wrap: 3*FIFO_DEPTH commands with random stalls -> responses in command order, none lost or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, command record and sequencer state encoding for the ALU sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_MOD = 4'b1010;
    localparam logic [3:0] ALU_LT  = 4'b1011;
    localparam logic [3:0] ALU_EQ  = 4'b1100;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] a;
        logic [3:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_RESP  = 2'b10
    } seq_state_t;

    // Division by zero and opcodes beyond the defined set are reported as errors.
    function automatic logic cmd_is_err(input logic [3:0] sel, input logic [3:0] b);
        return (((sel == ALU_DIV) || (sel == ALU_MOD)) && (b == 4'b0000)) || (sel > ALU_EQ);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and occupancy counter.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the registered flags and derive the next occupancy.
    always_comb begin
        push_ok_s    = push && !full_r;
        pop_ok_s     = pop && !empty_r;
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers and flags; full reads high during reset so upstream is held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b1;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == {CW{1'b0}});
        end
    end

    // Storage array; contents are only meaningful between valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, drives an external combinational ALU and captures results.
// Optional build macro: ALU_SEQ_ERR_CHECK_EN enables illegal-operation error reporting.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_sel,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_err
);

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYC - 1);

    seq_state_t state_r;
    seq_state_t state_next_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    alu_cmd_t   push_cmd_s;
    alu_cmd_t   head_s;
    logic       full_s;
    logic       empty_s;
    logic       push_s;
    logic       pop_s;
    logic       capture_s;
    logic       clear_s;
    logic [3:0] alu_sel_r;
    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;
    logic       rsp_carry_r;
    logic       rsp_err_r;
    logic [7:0] data_s;
    logic       carry_s;
    logic       err_s;

    assign push_cmd_s = '{sel: cmd_sel, a: cmd_a, b: cmd_b};
    assign push_s     = cmd_valid && !full_s;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(alu_cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_cmd_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sequencing: pop into DRIVE, wait out the settle time, then hold the result in RESP.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    cnt_next_s   = SETTLE_M1;
                    state_next_s = ST_DRIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_r != 4'd0) begin
                    cnt_next_s = cnt_r - 4'd1;
                end else begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    clear_s = 1'b1;
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        cnt_next_s   = SETTLE_M1;
                        state_next_s = ST_DRIVE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                cnt_next_s   = 4'd0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Result as presented to the consumer, with illegal operations squashed when checking is built in.
    always_comb begin
`ifdef ALU_SEQ_ERR_CHECK_EN
        err_s = cmd_is_err(alu_sel_r, alu_b_r);
        if (err_s) begin
            data_s  = 8'h00;
            carry_s = 1'b0;
        end else begin
            data_s  = alu_out;
            carry_s = alu_carry;
        end
`else
        err_s   = 1'b0;
        data_s  = alu_out;
        carry_s = alu_carry;
`endif
    end

    // State and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // ALU operand registers, loaded only when a command leaves the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel_r <= 4'd0;
            alu_a_r   <= 4'd0;
            alu_b_r   <= 4'd0;
        end else if (pop_s) begin
            alu_sel_r <= head_s.sel;
            alu_a_r   <= head_s.a;
            alu_b_r   <= head_s.b;
        end
    end

    // Response holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_carry_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= data_s;
            rsp_carry_r <= carry_s;
            rsp_err_r   <= err_s;
        end else if (clear_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign cmd_ready = !full_s;
    assign alu_sel   = alu_sel_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_carry = rsp_carry_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and response model.
module tb_alu_sequencer;

    localparam int D = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_sel = 4'd0;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;
    logic [3:0] alu_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.FIFO_DEPTH(D), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    // Behavioural ALU: returns {carry, result}.
    function automatic logic [8:0] alu_f(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        int x, y;
        x = a; y = b;
        case (sel)
            4'd0:    return {(x + y) > 15, 8'(x + y)};
            4'd1:    return {(x < y), 8'(x - y)};
            4'd2:    return {1'b0, 8'(x & y)};
            4'd3:    return {1'b0, 8'(x | y)};
            4'd4:    return {1'b0, 8'(x ^ y)};
            4'd5:    return {1'b0, 8'(15 - x)};
            4'd6:    return {1'b0, 8'(x << (y % 4))};
            4'd7:    return {1'b0, 8'(x >> (y % 4))};
            4'd8:    return {1'b0, 8'(x * y)};
            4'd9:    return (y == 0) ? {1'b1, 8'hFF} : {1'b0, 8'(x / y)};
            4'd10:   return (y == 0) ? {1'b1, 8'(x)} : {1'b0, 8'(x % y)};
            4'd11:   return {1'b0, 8'(x < y)};
            4'd12:   return {1'b0, 8'(x == y)};
            default: return {1'b1, 8'hAA};
        endcase
    endfunction

    always_comb {alu_carry, alu_out} = alu_f(alu_sel, alu_a, alu_b);

    // Expected response {err, carry, data} for a command.
    function automatic logic [9:0] exp_f(input logic [11:0] c);
        logic e;
        e = 1'b0;
`ifdef ALU_SEQ_ERR_CHECK_EN
        e = (((c[11:8] == 4'd9) || (c[11:8] == 4'd10)) && (c[3:0] == 4'd0)) || (c[11:8] > 4'd12);
`endif
        return e ? 10'b10_0000_0000 : {1'b0, alu_f(c[11:8], c[7:4], c[3:0])};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_carry, rsp_err} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b sel=%h a=%h b=%h v=%b d=%h c=%b e=%b, expected all 0",
                     cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_carry, rsp_err);
        end
        rst_n = 1'b1;
        tick;
        n_tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b v=%b, expected rdy=1 v=0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_single_op;
        rsp_ready = 1'b0;
        {cmd_sel, cmd_a, cmd_b} = {4'b0000, 4'd3, 4'd4};
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        for (int k = 1; k <= S + 2; k++) begin
            n_tests++;
            if (rsp_valid !== (k == S + 2)) begin
                n_fail++;
                $display("FAIL latency cycle N+%0d: got rsp_valid=%b expected %b", k, rsp_valid, (k == S + 2));
            end
            if (k == S + 1) begin
                n_tests++;
                if ({alu_sel, alu_a, alu_b} !== 12'h034) begin
                    n_fail++;
                    $display("FAIL alu_drive: got %h expected 034", {alu_sel, alu_a, alu_b});
                end
            end
            if (k < S + 2) tick;
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({rsp_valid, rsp_err, rsp_carry, rsp_data} !== {3'b100, 8'h07}) begin
                n_fail++;
                $display("FAIL single_op_hold: got v=%b e=%b c=%b d=%h expected v=1 e=0 c=0 d=07",
                         rsp_valid, rsp_err, rsp_carry, rsp_data);
            end
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_op_clear: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [11:0] cmds [6];
        logic [9:0]  exp_q [$];
        logic [9:0]  e;
        int sent = 0, got = 0, k = 0;
        logic acc;
        cmds[0] = {4'b0010, 4'hC, 4'hA};
        for (int i = 1; i < 6; i++) cmds[i] = {4'($urandom_range(0, 12)), 4'($urandom), 4'($urandom)};
        rsp_ready = 1'b0;
        while (sent < 5 && k < 40) begin
            {cmd_sel, cmd_a, cmd_b} = cmds[sent];
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                exp_q.push_back(exp_f(cmds[sent]));
                sent++;
            end
            tick;
            k++;
        end
        {cmd_sel, cmd_a, cmd_b} = cmds[5];
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'h08) begin
                n_fail++;
                $display("FAIL backpressure_hold %0d: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=08",
                         i, cmd_ready, rsp_valid, rsp_data);
            end
            tick;
        end
        rsp_ready = 1'b1;
        k = 0;
        while (got < 6 && k < 80) begin
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                exp_q.push_back(exp_f(cmds[5]));
                sent++;
            end
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                if ({rsp_err, rsp_carry, rsp_data} !== e) begin
                    n_fail++;
                    $display("FAIL backpressure_rsp %0d: got %h expected %h", got, {rsp_err, rsp_carry, rsp_data}, e);
                end
                got++;
            end
            tick;
            if (acc) cmd_valid = 1'b0;
            k++;
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (got != 6 || sent != 6) begin
            n_fail++;
            $display("FAIL backpressure_count: got %0d responses %0d sent, expected 6 and 6", got, sent);
        end
    endtask

    task automatic test_streaming;
        int sent = 0, got = 0, last = -1, k = 0;
        rsp_ready = 1'b1;
        {cmd_sel, cmd_a, cmd_b} = {4'b1000, 4'hF, 4'hF};
        while (got < 8 && k < 200) begin
            cmd_valid = (sent < 8);
            if (cmd_valid && cmd_ready) sent++;
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                if ({rsp_err, rsp_carry, rsp_data} !== {2'b00, 8'hE1}) begin
                    n_fail++;
                    $display("FAIL stream_data %0d: got %h expected 0e1", got, {rsp_err, rsp_carry, rsp_data});
                end
                if (last >= 0) begin
                    n_tests++;
                    if (k - last != S + 1) begin
                        n_fail++;
                        $display("FAIL stream_spacing %0d: got %0d cycles expected %0d", got, k - last, S + 1);
                    end
                end
                last = k;
                got++;
            end
            tick;
            k++;
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 8", got);
        end
    endtask

    task automatic test_wrap;
        logic [11:0] c;
        logic [9:0]  exp_q [$];
        logic [9:0]  e;
        int sent = 0, got = 0, k = 0;
        logic extra = 1'b0;
        c = 12'($urandom);
        while (got < 3 * D && k < 2000) begin
            cmd_valid = (sent < 3 * D) && ($urandom_range(0, 99) < 70);
            {cmd_sel, cmd_a, cmd_b} = c;
            rsp_ready = ($urandom_range(0, 99) < 50);
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(exp_f(c));
                sent++;
                c = 12'($urandom);
            end
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                if ({rsp_err, rsp_carry, rsp_data} !== e) begin
                    n_fail++;
                    $display("FAIL wrap_rsp %0d: got %h expected %h", got, {rsp_err, rsp_carry, rsp_data}, e);
                end
                got++;
            end
            tick;
            k++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) extra = 1'b1;
            tick;
        end
        n_tests++;
        if (got != 3 * D || extra || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d responses extra=%b pending=%0d, expected %0d 0 0",
                     got, extra, exp_q.size(), 3 * D);
        end
    endtask

`ifdef ALU_SEQ_ERR_CHECK_EN
    task automatic test_err_check;
        logic [9:0] want;
        int k;
        for (int i = 0; i < 2; i++) begin
            rsp_ready = 1'b0;
            {cmd_sel, cmd_a, cmd_b} = {4'b1001, 4'd7, (i == 0) ? 4'd0 : 4'd2};
            want = (i == 0) ? 10'h200 : 10'h003;
            cmd_valid = 1'b1;
            tick;
            cmd_valid = 1'b0;
            k = 0;
            while (!rsp_valid && k < 20) begin
                tick;
                k++;
            end
            n_tests++;
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_carry, rsp_data} !== want) begin
                n_fail++;
                $display("FAIL err_check %0d: got v=%b %h expected v=1 %h", i, rsp_valid, {rsp_err, rsp_carry, rsp_data}, want);
            end
            rsp_ready = 1'b1;
            tick;
        end
        rsp_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_midop;
        logic [11:0] c [3];
        logic seen = 1'b0;
        c[0] = {4'b0001, 4'd5, 4'd9};
        c[1] = {4'($urandom_range(0, 12)), 4'($urandom), 4'($urandom)};
        c[2] = {4'($urandom_range(0, 12)), 4'($urandom), 4'($urandom)};
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {cmd_sel, cmd_a, cmd_b} = c[i];
            cmd_valid = 1'b1;
            tick;
        end
        cmd_valid = 1'b0;
        n_tests++;
        if ({alu_sel, alu_a, alu_b} !== c[0] || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_drive: got %h v=%b expected %h v=0", {alu_sel, alu_a, alu_b}, rsp_valid, c[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, alu_sel, alu_a, alu_b, cmd_ready} !== 14'd0) begin
            n_fail++;
            $display("FAIL midop_async_reset: got v=%b alu=%h rdy=%b expected all 0",
                     rsp_valid, {alu_sel, alu_a, alu_b}, cmd_ready);
        end
        tick;
        tick;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_after_release: got rsp_seen=%b rdy=%b expected 0 1", seen, cmd_ready);
        end
    endtask

    initial begin
        test_reset;
        test_single_op;
        test_backpressure;
        test_streaming;
        test_wrap;
`ifdef ALU_SEQ_ERR_CHECK_EN
        test_err_check;
`endif
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
